// File: rtl/cpu_pkg.sv
// Shared pipeline types for the 64-bit ARM core: destination-tracking slot,
// EX operand forward selects and the architectural zero register index.
package cpu_pkg;

  // XZR: reads as zero, writes are discarded, so it never carries a dependency.
  localparam logic [4:0] XZR = 5'd31;

  // One in-flight instruction's destination information.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } dest_slot_t;

  // EX-stage ALU operand source.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Priority select for one operand: the nearer producer wins. A load in the
  // ex slot has no result yet, so it cannot feed EX/MEM forwarding.
  function automatic fwd_sel_t pick_fwd(input logic ex_hit,
                                        input logic ex_load,
                                        input logic mem_hit);
    if (ex_hit && !ex_load) begin
      return FWD_EXMEM;
    end else if (mem_hit) begin
      return FWD_MEMWB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/eq_cmp5.sv
// 5-bit equality comparator used for register-index matching.
module eq_cmp5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic       eq
);

  // Bitwise XNOR reduced with AND: all bits agree.
  assign eq = &(a ~^ b);

endmodule

// File: rtl/reg_match.sv
// Gated match of one source register against one destination-tracking slot.
// A hit means the slot holds a live write to that register, and the register
// is not the zero register.
module reg_match
  import cpu_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = XZR
) (
  input  dest_slot_t slot,
  input  logic [4:0] src,
  output logic       hit,
  output logic       load_hit
);

  logic rd_eq;
  logic src_is_zero;

  eq_cmp5 u_rd_eq (
    .a  (slot.rd),
    .b  (src),
    .eq (rd_eq)
  );

  eq_cmp5 u_zero_eq (
    .a  (src),
    .b  (ZERO_REG),
    .eq (src_is_zero)
  );

  assign hit      = slot.valid & slot.reg_write & rd_eq & ~src_is_zero;
  // Hit whose producer is a load: its data only exists after MEM.
  assign load_hit = hit & slot.mem_read;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: tracks destinations in EX/MEM/WB, compares them
// with the ID-stage sources, and produces registered EX forward selects, the
// WB-to-ID bypass, the one-cycle load-use stall and a saturating stall counter.
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = XZR,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             byp_a,
  output logic             byp_b,
  output logic [CNT_W-1:0] stall_count
);

  // Index 0 = ex, 1 = mem, 2 = wb.
  dest_slot_t slots [3];

  logic [2:0] rn_hit;
  logic [2:0] rm_hit;
  logic [2:0] rn_load_hit;
  logic [2:0] rm_load_hit;

  fwd_sel_t   fwd_a_reg;
  fwd_sel_t   fwd_b_reg;
  fwd_sel_t   fwd_a_next;
  fwd_sel_t   fwd_b_next;
  dest_slot_t ex_next;
  logic       advance;

  logic [CNT_W-1:0] stall_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_match
      reg_match #(.ZERO_REG(ZERO_REG)) u_rn_match (
        .slot     (slots[gi]),
        .src      (id_rn),
        .hit      (rn_hit[gi]),
        .load_hit (rn_load_hit[gi])
      );
      reg_match #(.ZERO_REG(ZERO_REG)) u_rm_match (
        .slot     (slots[gi]),
        .src      (id_rm),
        .hit      (rm_hit[gi]),
        .load_hit (rm_load_hit[gi])
      );
    end
  endgenerate

  // Loads already in mem or wb have their data available; only the ex-slot
  // load hit matters, so the later ones are deliberately left unconsumed.
  logic unused_late_load_hits;
  assign unused_late_load_hits = |{rn_load_hit[2:1], rm_load_hit[2:1]};

  // Load-use hazard: consumer in ID directly behind a load in EX. Flush wins.
  assign stall = id_valid & ~flush &
                 (rn_load_hit[0] | (id_uses_rm & rm_load_hit[0]));

  // Register-file write in WB lands too late for the ID read; bypass it.
  assign byp_a = id_valid & rn_hit[2];
  assign byp_b = id_valid & id_uses_rm & rm_hit[2];

  assign advance = id_valid & ~flush & ~stall;

  // Next ex-slot contents and forward selects for the instruction leaving ID.
  always_comb begin
    ex_next    = '0;
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (advance) begin
      ex_next.valid     = 1'b1;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
      fwd_a_next        = pick_fwd(rn_hit[0], rn_load_hit[0], rn_hit[1]);
      if (id_uses_rm) begin
        fwd_b_next = pick_fwd(rm_hit[0], rm_load_hit[0], rm_hit[1]);
      end
    end
  end

  // Advance the tracking pipeline and register the EX operand selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        slots[i] <= '0;
      end
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else begin
      slots[2]  <= slots[1];
      slots[1]  <= slots[0];
      slots[0]  <= ex_next;
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign fwd_a       = fwd_a_reg;
  assign fwd_b       = fwd_b_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios,
// randomized instruction streams against a producer-distance reference model,
// asynchronous mid-stall reset and counter saturation.
module tb_hazard_forward_unit;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CW = 10;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rn;
  logic [4:0]    id_rm;
  logic          id_uses_rm;
  logic [4:0]    id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic          stall;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          byp_a;
  logic          byp_b;
  logic [CW-1:0] stall_count;

  hazard_forward_unit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rm   (id_uses_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .byp_a        (byp_a),
    .byp_b        (byp_b),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tx       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the instructions that have entered EX, newest first.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ins_t;

  ins_t pipe [3];
  int   m_count;
  int   m_fwd_a;
  int   m_fwd_b;
  bit   last_stall;
  bit   last_byp_a;

  function automatic bit writes(input ins_t p, input logic [4:0] s);
    return p.v && p.rw && (p.rd == s) && (s != 5'd31);
  endfunction

  // How many instructions back the most recent in-flight producer of s is.
  function automatic int producer_dist(input logic [4:0] s);
    for (int d = 0; d < 3; d++) begin
      if (writes(pipe[d], s)) return d;
    end
    return -1;
  endfunction

  // Value an EX operand needs: distance 0 from EX/MEM, distance 1 from MEM/WB.
  function automatic int fwd_for(input logic [4:0] s);
    int d;
    d = producer_dist(s);
    if (d == 0) return 1;
    if (d == 1) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 5'd0, 0, 0};
    m_count = 0;
    m_fwd_a = 0;
    m_fwd_b = 0;
  endtask

  task automatic drive(input bit v, input logic [4:0] rn, input logic [4:0] rm, input bit urm,
                       input logic [4:0] rd, input bit rw, input bit mr, input bit fl);
    id_valid     = v;
    id_rn        = rn;
    id_rm        = rm;
    id_uses_rm   = urm;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  // One ID-stage cycle: drive, check combinational outputs, clock, check state.
  task automatic step(input bit v, input logic [4:0] rn, input logic [4:0] rm, input bit urm,
                      input logic [4:0] rd, input bit rw, input bit mr, input bit fl);
    bit e_stall, e_byp_a, e_byp_b, enter;
    drive(v, rn, rm, urm, rd, rw, mr, fl);
    #2;
    e_stall = v && !fl && pipe[0].mr &&
              ((producer_dist(rn) == 0) || (urm && producer_dist(rm) == 0));
    e_byp_a = v && writes(pipe[2], rn);
    e_byp_b = v && urm && writes(pipe[2], rm);
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("byp_a", {31'd0, byp_a}, {31'd0, e_byp_a});
    check("byp_b", {31'd0, byp_b}, {31'd0, e_byp_b});
    last_stall = stall;
    last_byp_a = byp_a;
    enter   = v && !e_stall && !fl;
    m_fwd_a = enter ? fwd_for(rn) : 0;
    m_fwd_b = (enter && urm) ? fwd_for(rm) : 0;
    if (e_stall && m_count < (1 << CW) - 1) m_count++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = enter ? '{1, rd, rw, mr} : '{0, 5'd0, 0, 0};
    @(posedge clk);
    #1;
    check("fwd_a", {30'd0, fwd_a}, m_fwd_a);
    check("fwd_b", {30'd0, fwd_b}, m_fwd_b);
    check("stall_count", {{(32-CW){1'b0}}, stall_count}, m_count);
    $display("tx %0d v=%b rn=%0d rm=%0d urm=%b rd=%0d rw=%b mr=%b fl=%b | stall=%b byp=%b%b fwd=%0d/%0d cnt=%0d",
             tx, v, rn, rm, urm, rd, rw, mr, fl, last_stall, last_byp_a, e_byp_b, fwd_a, fwd_b, stall_count);
    tx++;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    int saved;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    check("reset_fwd_a", {30'd0, fwd_a}, 0);
    check("reset_fwd_b", {30'd0, fwd_b}, 0);
    check("reset_count", {{(32-CW){1'b0}}, stall_count}, 0);
    check("reset_stall", {31'd0, stall}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD X1 ; SUB X2,X1,X3
    step(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
    step(1, 5'd1, 5'd3, 1, 5'd2, 1, 0, 0);
    check("sub_fwd_a", {30'd0, fwd_a}, 1);
    check("sub_fwd_b", {30'd0, fwd_b}, 0);

    // LDUR X4 ; ADD X5,X4,X4 (held in ID across the stall)
    step(1, 5'd9, 5'd0, 0, 5'd4, 1, 1, 0);
    step(1, 5'd4, 5'd4, 1, 5'd5, 1, 0, 0);
    check("lu_stall", {31'd0, last_stall}, 1);
    check("lu_count", {{(32-CW){1'b0}}, stall_count}, 1);
    step(1, 5'd4, 5'd4, 1, 5'd5, 1, 0, 0);
    check("lu_stall_done", {31'd0, last_stall}, 0);
    check("lu_fwd_a", {30'd0, fwd_a}, 2);
    check("lu_fwd_b", {30'd0, fwd_b}, 2);

    // X31 producer never forwards or stalls
    step(1, 5'd1, 5'd2, 1, 5'd31, 1, 0, 0);
    step(1, 5'd31, 5'd31, 1, 5'd12, 1, 0, 0);
    check("xzr_fwd_a", {30'd0, fwd_a}, 0);
    check("xzr_fwd_b", {30'd0, fwd_b}, 0);
    step(1, 5'd1, 5'd0, 0, 5'd31, 1, 1, 0);
    step(1, 5'd31, 5'd31, 1, 5'd31, 1, 0, 0);
    check("xzr_load_stall", {31'd0, last_stall}, 0);

    // Two writers of X6: nearer wins
    step(1, 5'd1, 5'd2, 1, 5'd6, 1, 0, 0);
    step(1, 5'd1, 5'd2, 1, 5'd6, 1, 0, 0);
    step(1, 5'd6, 5'd6, 1, 5'd13, 1, 0, 0);
    check("near_fwd_a", {30'd0, fwd_a}, 1);

    // Writer of X7, two unrelated, reader of X7 sees WB bypass
    step(1, 5'd12, 5'd12, 0, 5'd7, 1, 0, 0);
    step(1, 5'd12, 5'd12, 0, 5'd10, 1, 0, 0);
    step(1, 5'd12, 5'd12, 0, 5'd11, 1, 0, 0);
    step(1, 5'd7, 5'd12, 1, 5'd14, 1, 0, 0);
    check("wb_byp_a", {31'd0, last_byp_a}, 1);

    // LDUR X8 ; consumer flushed: no stall, bubble, counter unchanged
    step(1, 5'd12, 5'd0, 0, 5'd8, 1, 1, 0);
    saved = m_count;
    step(1, 5'd8, 5'd8, 1, 5'd9, 1, 0, 1);
    check("flush_stall", {31'd0, last_stall}, 0);
    check("flush_count", {{(32-CW){1'b0}}, stall_count}, saved);
    step(1, 5'd8, 5'd9, 1, 5'd15, 1, 0, 0);
    check("flush_bubble_fwd_a", {30'd0, fwd_a}, 2);
    check("flush_bubble_fwd_b", {30'd0, fwd_b}, 0);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
           rnd_reg(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Reset asserted in the middle of a stall cycle
    step(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
    step(1, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0);
    drive(1, 5'd4, 5'd4, 1, 5'd5, 1, 0, 0);
    #2;
    check("pre_reset_stall", {31'd0, stall}, 1);
    check("pre_reset_fwd_a", {30'd0, fwd_a}, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_stall", {31'd0, stall}, 0);
    check("mid_reset_fwd_a", {30'd0, fwd_a}, 0);
    check("mid_reset_fwd_b", {30'd0, fwd_b}, 0);
    check("mid_reset_count", {{(32-CW){1'b0}}, stall_count}, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back dependent loads: a stall every other cycle until saturation
    for (int i = 0; i < 2 * ((1 << CW) + 3); i++) begin
      step(1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 0);
    end
    check("sat_count", {{(32-CW){1'b0}}, stall_count}, (1 << CW) - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
